minibyte_ctrl: RTL and testbench
================================

// Module: minibyte_ctrl
// PURPOSE
//  Instruction sequencer for the minibyte CPU datapath (A/M/PC regs, addr mux, ALU).
//  Fetches opcode/operand bytes from data_in and drives every datapath strobe, the ALU op and we_out.
//  Holds the instruction register and registered Z/N flags.
//  Sits beside the datapath inside minibyte_cpu and replaces its tied-off control signals.
// PARAMETERS
//  HALT_ON_ILLEGAL  1  1: opcodes 0xC-0xE enter S_HALT; 0: treated as NOP
// PORTS
//  clk_in         in   1  clock, all state on rising edge
//  rst_in         in   1  asynchronous, active-low reset
//  en_in          in   1  1: advance; 0: stall (state/IR/flags held, all strobes 0)
//  data_in        in   8  memory read data (opcode/operand source)
//  flag_z_in      in   1  ALU zero flag (combinational, of current ALU result)
//  flag_n_in      in   1  ALU negative flag
//  ctrl_set_a     out  1  load A from main bus
//  ctrl_set_m     out  1  load M from main bus
//  ctrl_set_pc    out  1  load PC from main bus
//  ctrl_inc_pc    out  1  PC <= PC+1 (8-bit wrap, 0xFF->0x00)
//  ctrl_addr_mux  out  1  0: addr=PC, 1: addr=M
//  ctrl_alu_op    out  3  ALU op: 0 PASSB,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 PASSA,7 rsvd
//  we_out         out  1  memory write strobe (data = A)
//  halted_out     out  1  1 while in S_HALT
// BEHAVIOUR
//  Reset (rst_in=0): state=S_FETCH, IR=0, Z=N=0; all strobes/we_out 0, addr_mux 0, alu_op PASSB, halted 0.
//  Opcode = data_in[7:4], low nibble ignored: 0 NOP,1 LDI,2 LDA,3 STA,4 ADD,5 SUB,6 AND,7 OR,
//   8 XOR,9 JMP,A BZ,B BN,F HLT; C-E illegal. All non-NOP/HLT take one operand byte.
//  Outputs combinational from (state, IR, Z, N); gated to 0 when en_in=0 or in reset.
//  S_FETCH: addr_mux=0, alu PASSB, inc_pc=1, IR<=opcode.
//   -> NOP: S_FETCH; HLT/illegal(HALT_ON_ILLEGAL=1): S_HALT; else S_OPER.
//  S_OPER: addr_mux=0, alu PASSB (bus=operand).
//   LDI: set_a, inc_pc, Z/N<=flags -> S_FETCH.  JMP: set_pc -> S_FETCH.
//   BZ/BN: Z/N=1 ? set_pc : inc_pc -> S_FETCH (registered flag, not flag_*_in).
//   LDA/STA/ALU ops: set_m, inc_pc -> S_EXEC.
//  S_EXEC: addr_mux=1.
//   LDA: alu PASSB, set_a.  ADD..XOR: matching alu op, set_a.  STA: alu PASSA, we_out=1.
//   Z/N<=flag_z_in/flag_n_in whenever set_a=1; otherwise held. -> S_FETCH.
//  S_HALT: all strobes 0, halted_out=1; exit only via reset.
//  Cycle counts (en_in=1): NOP 1, LDI/JMP/BZ/BN 2, LDA/STA/ALU 3.
//  Strobes are mutually consistent: set_pc and inc_pc never both 1; we_out only in S_EXEC.
//  en_in=0 mid-instruction: freeze; resume at same state with no replayed/lost strobe.
//  Reset mid-instruction: immediate return to reset values; partial instruction abandoned.
// STRUCTURE
//  Shared include minibyte_defs.vh: opcode constants, ALU op codes, state encodings
//   (S_FETCH=0,S_OPER=1,S_EXEC=2,S_HALT=3) -- reused by cpu top and bench.
//  Single module; no sub-module (2-bit state reg + 4-bit IR + Z/N regs + decode).
// TESTING
//  Mem{00:10,01:5A,02:F0}, reset release -> A=0x5A after 3 clk, PC=03, halted_out=1 at clk 4.
//  LDI 0x03; ADD [0x80]=0xFD -> A=0x00, Z=1; BZ 0x40 -> PC=0x40 on 2nd BZ cycle.
//  LDI 0x01; BN 0x40 -> not taken, PC=prev+2, set_pc never asserted.
//  LDI 0x77; STA 0x90 -> we_out=1 exactly one cycle, addr_mux=1, alu_op=6, M=0x90.
//  en_in=0 for 4 cycles in S_OPER of LDA -> strobes 0, state held; completes 3 active cycles total.
//  rst_in low during S_EXEC of STA -> we_out drops async, state=S_FETCH; opcode 0xC0 -> halted_out=1.

Source files
------------

// File: rtl/minibyte_pkg.sv
// -----------------------------------------------------------------------------
// minibyte_pkg
// Shared definitions for the minibyte CPU control path: sequencer state
// encoding, ALU operation codes, opcode values and small decode helpers.
// Imported by minibyte_ctrl and usable by the CPU top.
// -----------------------------------------------------------------------------
package minibyte_pkg;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_OPER  = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ALU_PASSB = 3'd0,
      ALU_ADD   = 3'd1,
      ALU_SUB   = 3'd2,
      ALU_AND   = 3'd3,
      ALU_OR    = 3'd4,
      ALU_XOR   = 3'd5,
      ALU_PASSA = 3'd6,
      ALU_RSVD  = 3'd7
   } alu_op_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_BZ  = 4'hA;
   localparam logic [3:0] OP_BN  = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   // 0xC..0xE have no defined behaviour.
   function automatic logic is_illegal(input logic [3:0] op);
      return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
   endfunction

   // Instructions that go through S_EXEC: operand is a memory address in M.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op >= OP_LDA) && (op <= OP_XOR);
   endfunction

   // ALU operation for the two-operand arithmetic/logic instructions.
   function automatic alu_op_t alu_for_op(input logic [3:0] op);
      alu_op_t r;
      case (op)
         OP_ADD:  r = ALU_ADD;
         OP_SUB:  r = ALU_SUB;
         OP_AND:  r = ALU_AND;
         OP_OR:   r = ALU_OR;
         OP_XOR:  r = ALU_XOR;
         default: r = ALU_PASSB;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/minibyte_ctrl.sv
// -----------------------------------------------------------------------------
// minibyte_ctrl
// Instruction sequencer for the minibyte CPU datapath. Fetches opcode and
// operand bytes from memory read data, holds the instruction register and the
// registered Z/N flags, and drives every datapath strobe, the ALU op and the
// memory write strobe.
//
// Ports
//   clk_in        clock, all state on rising edge
//   rst_in        asynchronous active-low reset
//   en_in         1: advance, 0: stall (state held, all strobes 0)
//   data_in[7:0]  memory read data (opcode/operand source)
//   flag_z_in     ALU zero flag of the current ALU result
//   flag_n_in     ALU negative flag of the current ALU result
//   ctrl_set_a    load A from main bus
//   ctrl_set_m    load M from main bus
//   ctrl_set_pc   load PC from main bus
//   ctrl_inc_pc   increment PC
//   ctrl_addr_mux 0: addr=PC, 1: addr=M
//   ctrl_alu_op   ALU operation select
//   we_out        memory write strobe (data = A)
//   halted_out    1 while halted
// -----------------------------------------------------------------------------
module minibyte_ctrl
   import minibyte_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       en_in,
   input  logic [7:0] data_in,
   input  logic       flag_z_in,
   input  logic       flag_n_in,
   output logic       ctrl_set_a,
   output logic       ctrl_set_m,
   output logic       ctrl_set_pc,
   output logic       ctrl_inc_pc,
   output logic       ctrl_addr_mux,
   output logic [2:0] ctrl_alu_op,
   output logic       we_out,
   output logic       halted_out
);

   state_t     state_reg, state_next;
   logic [3:0] ir_reg, ir_next;
   logic       z_reg, z_next;
   logic       n_reg, n_next;

   logic       set_a_raw, set_m_raw, set_pc_raw, inc_pc_raw;
   logic       addr_mux_raw, we_raw;
   alu_op_t    alu_op_raw;
   logic       active;
   logic [3:0] opcode;

   // Only the high nibble carries the opcode.
   logic       unused_low_nibble;
   assign unused_low_nibble = ^data_in[3:0];
   assign opcode            = data_in[7:4];

   // Strobes are suppressed while stalled and while reset is asserted, so a
   // reset mid-cycle drops them immediately rather than at the next edge.
   assign active = en_in & rst_in;

   always_comb begin
      state_next   = state_reg;
      ir_next      = ir_reg;
      z_next       = z_reg;
      n_next       = n_reg;
      set_a_raw    = 1'b0;
      set_m_raw    = 1'b0;
      set_pc_raw   = 1'b0;
      inc_pc_raw   = 1'b0;
      addr_mux_raw = 1'b0;
      we_raw       = 1'b0;
      alu_op_raw   = ALU_PASSB;

      case (state_reg)
         S_FETCH: begin
            inc_pc_raw = 1'b1;
            ir_next    = opcode;
            if (opcode == OP_HLT || (HALT_ON_ILLEGAL && is_illegal(opcode)))
               state_next = S_HALT;
            else if (opcode == OP_NOP || is_illegal(opcode))
               state_next = S_FETCH;
            else
               state_next = S_OPER;
         end

         S_OPER: begin
            // Operand byte is on the bus via ALU PASSB.
            state_next = S_FETCH;
            case (ir_reg)
               OP_LDI: begin
                  set_a_raw  = 1'b1;
                  inc_pc_raw = 1'b1;
               end
               OP_JMP: set_pc_raw = 1'b1;
               // Branches test the registered flags, not the live ALU flags.
               OP_BZ: begin
                  set_pc_raw = z_reg;
                  inc_pc_raw = ~z_reg;
               end
               OP_BN: begin
                  set_pc_raw = n_reg;
                  inc_pc_raw = ~n_reg;
               end
               default: begin
                  if (is_mem_op(ir_reg)) begin
                     set_m_raw  = 1'b1;
                     inc_pc_raw = 1'b1;
                     state_next = S_EXEC;
                  end
               end
            endcase
         end

         S_EXEC: begin
            addr_mux_raw = 1'b1;
            state_next   = S_FETCH;
            case (ir_reg)
               OP_LDA: set_a_raw = 1'b1;
               OP_STA: begin
                  alu_op_raw = ALU_PASSA;
                  we_raw     = 1'b1;
               end
               default: begin
                  set_a_raw  = 1'b1;
                  alu_op_raw = alu_for_op(ir_reg);
               end
            endcase
         end

         S_HALT: state_next = S_HALT;

         default: state_next = S_FETCH;
      endcase

      // Flags track whatever value lands in A.
      if (set_a_raw) begin
         z_next = flag_z_in;
         n_next = flag_n_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg <= S_FETCH;
         ir_reg    <= 4'h0;
         z_reg     <= 1'b0;
         n_reg     <= 1'b0;
      end else if (en_in) begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
         z_reg     <= z_next;
         n_reg     <= n_next;
      end
   end

   assign ctrl_set_a    = set_a_raw    & active;
   assign ctrl_set_m    = set_m_raw    & active;
   assign ctrl_set_pc   = set_pc_raw   & active;
   assign ctrl_inc_pc   = inc_pc_raw   & active;
   assign ctrl_addr_mux = addr_mux_raw & active;
   assign we_out        = we_raw       & active;
   assign ctrl_alu_op   = active ? alu_op_raw : ALU_PASSB;
   assign halted_out    = (state_reg == S_HALT) & rst_in;

endmodule

// File: tb/tb_minibyte_ctrl.sv
// -----------------------------------------------------------------------------
// tb_minibyte_ctrl
// Wraps the sequencer in a small behavioural datapath (memory, A, M, PC, ALU).
// An instruction-level interpreter of the minibyte ISA turns each program into
// the expected per-cycle strobe trace plus architectural state at every fetch;
// a monitor pops and compares on every enabled clock.
// -----------------------------------------------------------------------------
module tb_minibyte_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] data;
   logic       flag_z, flag_n;
   logic       set_a, set_m, set_pc, inc_pc, addr_mux, we, halted;
   logic [2:0] alu_op;

   minibyte_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .en_in        (en),
      .data_in      (data),
      .flag_z_in    (flag_z),
      .flag_n_in    (flag_n),
      .ctrl_set_a   (set_a),
      .ctrl_set_m   (set_m),
      .ctrl_set_pc  (set_pc),
      .ctrl_inc_pc  (inc_pc),
      .ctrl_addr_mux(addr_mux),
      .ctrl_alu_op  (alu_op),
      .we_out       (we),
      .halted_out   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural datapath ----------------
   logic [7:0] img [256];
   logic [7:0] mem [256];
   logic [7:0] a_q, m_q, pc_q, addr, alu_res;

   assign addr = addr_mux ? m_q : pc_q;
   assign data = mem[addr];

   always_comb begin
      case (alu_op)
         3'd0:    alu_res = data;
         3'd1:    alu_res = a_q + data;
         3'd2:    alu_res = a_q - data;
         3'd3:    alu_res = a_q & data;
         3'd4:    alu_res = a_q | data;
         3'd5:    alu_res = a_q ^ data;
         3'd6:    alu_res = a_q;
         default: alu_res = 8'h00;
      endcase
   end
   assign flag_z = (alu_res == 8'h00);
   assign flag_n = alu_res[7];

   // Memory image is reloaded whenever reset is held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= 8'h00;
         m_q  <= 8'h00;
         pc_q <= 8'h00;
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else begin
         if (set_a) a_q <= alu_res;
         if (set_m) m_q <= alu_res;
         if (set_pc) pc_q <= alu_res;
         else if (inc_pc) pc_q <= pc_q + 8'd1;
         if (we) mem[addr] <= a_q;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic       sa, sm, sp, ip, mx;
      logic [2:0] alu;
      logic       w, h;
      logic       chk;
      logic [7:0] a, pc;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] req;
   } dchk_t;

   exp_t  exp_q[$];
   dchk_t dq[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   logic [7:0] fin_a, fin_pc;

   function automatic exp_t mk(input logic sa, sm, sp, ip, mx, input logic [2:0] al,
                               input logic w, h, chk, input logic [7:0] a, pc);
      exp_t e;
      e.sa = sa; e.sm = sm; e.sp = sp; e.ip = ip; e.mx = mx;
      e.alu = al; e.w = w; e.h = h; e.chk = chk; e.a = a; e.pc = pc;
      return e;
   endfunction

   task automatic post(input string nm, input logic [31:0] act, input logic [31:0] req);
      dchk_t d;
      d.name = nm; d.act = act; d.req = req;
      dq.push_back(d);
   endtask

   wire [9:0] obs = {set_a, set_m, set_pc, inc_pc, addr_mux, alu_op, we, halted};

   always @(negedge clk) begin : monitor
      dchk_t d;
      exp_t  e;
      logic [9:0] req;
      while (dq.size() > 0) begin
         d = dq.pop_front();
         n_checks++;
         if (d.act !== d.req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", d.name, d.act, d.req);
         end
      end
      if (!rst_n) begin
         n_checks++;
         if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %03h, want 000", obs);
         end
      end else if (!en) begin
         n_checks++;
         if (obs[9:1] !== 9'h000) begin
            n_fail++;
            $display("FAIL stall_strobes: got %03h, want 000", {obs[9:1], 1'b0});
         end
      end else if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_cycle: got strobes %03h, want no active cycle", obs);
      end else begin
         e = exp_q.pop_front();
         req = {e.sa, e.sm, e.sp, e.ip, e.mx, e.alu, e.w, e.h};
         n_checks++;
         if (obs !== req) begin
            n_fail++;
            $display("FAIL strobes @%0t: got %03h, want %03h", $time, obs, req);
         end
         if (e.chk) begin
            n_checks++;
            if (a_q !== e.a || pc_q !== e.pc) begin
               n_fail++;
               $display("FAIL fetch_state @%0t: got A=%02h PC=%02h, want A=%02h PC=%02h",
                        $time, a_q, pc_q, e.a, e.pc);
            end
         end
      end
   end

   // ---------------- ISA-level reference model ----------------
   task automatic build_trace(input int max_cycles);
      logic [7:0] mm [256];
      logic [7:0] pc, a, v, d, res;
      logic [3:0] op;
      logic [2:0] al;
      logic       z, n;
      int         cnt;
      for (int i = 0; i < 256; i++) mm[i] = img[i];
      pc = 8'h00; a = 8'h00; z = 1'b0; n = 1'b0; cnt = 0;
      while (cnt < max_cycles) begin
         op = mm[pc][7:4];
         exp_q.push_back(mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 1, a, pc));
         cnt++;
         pc = pc + 8'd1;
         if (op == 4'h0) continue;
         if (op >= 4'hC) begin
            repeat (3) exp_q.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 8'h00, 8'h00));
            break;
         end
         v = mm[pc];
         cnt++;
         case (op)
            4'h1: begin
               exp_q.push_back(mk(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 8'h00, 8'h00));
               a = v; z = (v == 8'h00); n = v[7]; pc = pc + 8'd1;
            end
            4'h9: begin
               exp_q.push_back(mk(0, 0, 1, 0, 0, 3'd0, 0, 0, 0, 8'h00, 8'h00));
               pc = v;
            end
            4'hA, 4'hB: begin
               if ((op == 4'hA) ? z : n) begin
                  exp_q.push_back(mk(0, 0, 1, 0, 0, 3'd0, 0, 0, 0, 8'h00, 8'h00));
                  pc = v;
               end else begin
                  exp_q.push_back(mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 8'h00, 8'h00));
                  pc = pc + 8'd1;
               end
            end
            default: begin
               exp_q.push_back(mk(0, 1, 0, 1, 0, 3'd0, 0, 0, 0, 8'h00, 8'h00));
               pc = pc + 8'd1;
               cnt++;
               d = mm[v];
               if (op == 4'h3) begin
                  exp_q.push_back(mk(0, 0, 0, 0, 1, 3'd6, 1, 0, 0, 8'h00, 8'h00));
                  mm[v] = a;
               end else begin
                  case (op)
                     4'h4:    begin res = a + d; al = 3'd1; end
                     4'h5:    begin res = a - d; al = 3'd2; end
                     4'h6:    begin res = a & d; al = 3'd3; end
                     4'h7:    begin res = a | d; al = 3'd4; end
                     4'h8:    begin res = a ^ d; al = 3'd5; end
                     default: begin res = d;     al = 3'd0; end
                  endcase
                  exp_q.push_back(mk(1, 0, 0, 0, 1, al, 0, 0, 0, 8'h00, 8'h00));
                  a = res; z = (res == 8'h00); n = res[7];
               end
            end
         endcase
      end
      fin_a  = a;
      fin_pc = pc;
   endtask

   // ---------------- stimulus ----------------
   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
   endtask

   task automatic rand_img();
      logic [7:0] b;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 7) != 0) b[7:4] = 4'($urandom_range(0, 11));
         img[i] = b;
      end
   endtask

   // mode 0: always enabled; 1: random stalls; 2: stall cycles 1..4
   task automatic run_segment(input string nm, input int mode, input int max_cycles);
      int k;
      rst_n = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      build_trace(max_cycles);
      rst_n = 1'b1;
      k = 0;
      while (exp_q.size() != 0) begin
         if (k >= 1000) begin
            post({nm, "_timeout"}, 32'd1, 32'd0);
            exp_q.delete();
            break;
         end
         case (mode)
            1:       en = ($urandom_range(0, 3) != 0);
            2:       en = !(k >= 1 && k <= 4);
            default: en = 1'b1;
         endcase
         @(posedge clk); #1;
         k++;
      end
      en = 1'b0;
      post({nm, "_final_a"},  32'(a_q),  32'(fin_a));
      post({nm, "_final_pc"}, 32'(pc_q), 32'(fin_pc));
   endtask

   task automatic sta_reset_test();
      bit found;
      clear_img();
      img[0] = 8'h10; img[1] = 8'h77; img[2] = 8'h30; img[3] = 8'h90; img[4] = 8'hF0;
      rst_n = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      build_trace(50);
      rst_n = 1'b1; en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (we) begin
            found = 1'b1;
            break;
         end
      end
      post("rst_sta_we_seen", 32'(found), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      post("rst_we_drop",  32'(we),       32'd0);
      post("rst_mux_drop", 32'(addr_mux), 32'd0);
      post("rst_alu_drop", 32'(alu_op),   32'd0);
      exp_q.delete();
      en = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      clear_img();

      // LDI 0x5A; HLT
      img[0] = 8'h10; img[1] = 8'h5A; img[2] = 8'hF0;
      run_segment("ldi_hlt", 0, 50);
      post("ldi_hlt_halted", 32'(halted), 32'd1);

      // LDI 3; ADD [80]=FD -> 0, Z=1; BZ 40 taken
      clear_img();
      img[0] = 8'h10; img[1] = 8'h03; img[2] = 8'h40; img[3] = 8'h80;
      img[4] = 8'hA0; img[5] = 8'h40; img[8'h40] = 8'hF0; img[8'h80] = 8'hFD;
      run_segment("bz_taken", 0, 50);

      // LDI 1; BN 40 not taken
      clear_img();
      img[0] = 8'h10; img[1] = 8'h01; img[2] = 8'hB0; img[3] = 8'h40; img[4] = 8'hF0;
      run_segment("bn_not_taken", 0, 50);

      // LDI 77; STA 90
      clear_img();
      img[0] = 8'h10; img[1] = 8'h77; img[2] = 8'h30; img[3] = 8'h90; img[4] = 8'hF0;
      run_segment("sta", 0, 50);
      post("sta_mem90", 32'(mem[8'h90]), 32'h77);
      post("sta_m",     32'(m_q),        32'h90);

      // LDA [50] with four stall cycles in the operand cycle
      clear_img();
      img[0] = 8'h20; img[1] = 8'h50; img[2] = 8'hF0; img[8'h50] = 8'hA5;
      run_segment("lda_stall", 2, 50);

      sta_reset_test();

      // illegal opcode halts
      clear_img();
      img[0] = 8'hC0;
      run_segment("illegal", 0, 20);
      post("illegal_halted", 32'(halted), 32'd1);

      for (int s = 0; s < 10; s++) begin
         rand_img();
         run_segment("random", 1, 80);
      end

      repeat (3) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
